// File: rtl/huff_rom_sched_pkg.sv
// Shared defaults and scheduler state type for the Huffman table ROM scheduler.
package huff_pkg;

  localparam int ROM_NUM_DEF    = 2;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int NUM_REQ_DEF    = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } sched_state_t;

  // Index width that stays legal even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/huff_rom_sched_rr_arb.sv
// Round-robin arbiter: priority starts just after the last granted requester,
// which resets to the highest index so requester 0 wins first.
module rr_arb
  import huff_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDXW   = idx_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDXW-1:0]    o_idx
);

  logic [IDXW-1:0] r_last;
  logic [IDXW-1:0] w_cand;
  logic            w_found;

  // Walk the requesters starting one past the last winner; first hit wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDXW'((int'(r_last) + k) % NUM_REQ);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= IDXW'(NUM_REQ - 1);
    end else if (w_found) begin
      r_last <= o_idx;
    end
  end

endmodule

// File: rtl/huff_rom_sched.sv
// Huffman table ROM scheduler: loads the code table into the ROM banks, then
// round-robins encoder lookups. Optional stall counter: HUFF_SCHED_STALL_CNT_EN.
module huff_rom_sched
  import huff_pkg::*;
#(
  parameter int ROM_NUM    = ROM_NUM_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REQ    = NUM_REQ_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [ADDR_WIDTH-1:0]         ld_addr,
  input  logic [ROM_NUM*DATA_WIDTH-1:0] ld_data,
  input  logic                          ld_last,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [ROM_NUM*DATA_WIDTH-1:0] rd_data,
  output logic                          tbl_valid,
  output logic [ROM_NUM*ADDR_WIDTH-1:0] rom_addr,
  output logic                          rom_we,
  output logic [ROM_NUM*DATA_WIDTH-1:0] rom_din,
  input  logic [ROM_NUM*DATA_WIDTH-1:0] rom_dout,
  output logic [15:0]                   stall_cnt
);

  localparam int IDXW = idx_width(NUM_REQ);

  sched_state_t                  r_state;
  sched_state_t                  w_stateNext;
  logic                          r_ldReady;
  logic                          w_ldFire;
  logic                          w_arbEn;
  logic [NUM_REQ-1:0]            w_gnt;
  logic [IDXW-1:0]               w_winIdx;
  logic [ADDR_WIDTH-1:0]         w_winAddr;
  logic [NUM_REQ-1:0]            r_rdValid;
  logic [ROM_NUM*DATA_WIDTH-1:0] r_rdData;

  // Loads always win over lookups, so reads are only arbitrated when idle.
  assign w_ldFire  = ld_valid && r_ldReady;
  assign w_arbEn   = (r_state == SERVE) && !ld_valid;
  assign w_winAddr = rd_addr[int'(w_winIdx)*ADDR_WIDTH +: ADDR_WIDTH];

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (rd_req),
    .i_en  (w_arbEn),
    .o_gnt (w_gnt),
    .o_idx (w_winIdx)
  );

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      EMPTY, LOAD: begin
        if (w_ldFire) begin
          w_stateNext = ld_last ? SERVE : LOAD;
        end
      end
      SERVE: begin
        if (w_ldFire && !ld_last) begin
          w_stateNext = LOAD;
        end
      end
      default: w_stateNext = EMPTY;
    endcase
  end

  // One shared index drives every bank: the load address or the read winner.
  always_comb begin
    rom_we   = w_ldFire;
    rom_addr = '0;
    rom_din  = '0;
    if (w_ldFire) begin
      rom_addr = {ROM_NUM{ld_addr}};
      rom_din  = ld_data;
    end else if (|w_gnt) begin
      rom_addr = {ROM_NUM{w_winAddr}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_ldReady <= 1'b0;
      r_rdValid <= '0;
      r_rdData  <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_ldReady <= 1'b1;
      r_rdValid <= w_gnt;
      if (|w_gnt) begin
        r_rdData <= rom_dout;
      end
    end
  end

  assign ld_ready  = r_ldReady;
  assign rd_gnt    = w_gnt;
  assign rd_valid  = r_rdValid;
  assign rd_data   = r_rdData;
  assign tbl_valid = (r_state == SERVE);

`ifdef HUFF_SCHED_STALL_CNT_EN
  logic [15:0] r_stallCnt;
  logic [16:0] w_stallSum;

  always_comb begin
    w_stallSum = {1'b0, r_stallCnt};
    for (int k = 0; k < NUM_REQ; k++) begin
      w_stallSum = w_stallSum + 17'(rd_req[k] & ~w_gnt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else begin
      r_stallCnt <= w_stallSum[16] ? 16'hFFFF : w_stallSum[15:0];
    end
  end

  assign stall_cnt = r_stallCnt;
`else
  assign stall_cnt = '0;
`endif

  a_gntOneHot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_gnt));
  a_noGntOnWrite: assert property (@(posedge clk) disable iff (!rst_n) !(rom_we && (|w_gnt)));

endmodule

// File: tb/tb_huff_rom_sched.sv
// Randomized self-checking bench for huff_rom_sched against a table/round-robin
// model; honours HUFF_SCHED_STALL_CNT_EN for the stall counter expectation.
module tb_huff_rom_sched;

  localparam int RN = 2;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int RW = RN * DW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ld_valid;
  logic             ld_ready;
  logic [AW-1:0]    ld_addr;
  logic [RW-1:0]    ld_data;
  logic             ld_last;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_gnt;
  logic [NR-1:0]    rd_valid;
  logic [RW-1:0]    rd_data;
  logic             tbl_valid;
  logic [RN*AW-1:0] rom_addr;
  logic             rom_we;
  logic [RW-1:0]    rom_din;
  logic [RW-1:0]    rom_dout;
  logic [15:0]      stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [RW-1:0]    mTable [256];
  bit               mTblValid;
  bit               mReady;
  int               mLastGnt;
  int               mStall;
  logic [NR-1:0]    expGnt;
  int               expWin;
  bit               expFire;
  logic [RN*AW-1:0] expAddr;
  logic [RW-1:0]    expDin;
  logic [NR-1:0]    expRdValid;
  logic [RW-1:0]    expRdData;

  always #5 clk = ~clk;

  huff_rom_sched #(
    .ROM_NUM(RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_last(ld_last),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .tbl_valid(tbl_valid),
    .rom_addr(rom_addr), .rom_we(rom_we), .rom_din(rom_din),
    .rom_dout(rom_dout), .stall_cnt(stall_cnt)
  );

  // ROM banks the scheduler drives
  logic [DW-1:0] romMem [RN][256];
  always @(posedge clk) begin
    if (rom_we) begin
      for (int k = 0; k < RN; k++) romMem[k][rom_addr[k*AW +: AW]] <= rom_din[k*DW +: DW];
    end
  end
  always_comb begin
    rom_dout = '0;
    for (int k = 0; k < RN; k++) rom_dout[k*DW +: DW] = romMem[k][rom_addr[k*AW +: AW]];
  end

  function automatic logic [RW-1:0] beat(input int i);
    return {64'(256 + i), 64'(i)};
  endfunction

  // Drive one cycle's inputs just after a falling edge and predict the
  // combinational outputs from the table/round-robin rules.
  task automatic drive(input bit ldv, input logic [AW-1:0] la, input logic [RW-1:0] ld,
                       input bit ll, input logic [NR-1:0] req, input logic [NR*AW-1:0] ra);
    bit found;
    int w;
    ld_valid = ldv; ld_addr = la; ld_data = ld; ld_last = ll;
    rd_req = req; rd_addr = ra;
    expFire = ldv && mReady;
    expGnt = '0; expWin = 0; expAddr = '0; expDin = '0; found = 0;
    if (mTblValid && !ldv) begin
      for (int k = 1; k <= NR; k++) begin
        w = (mLastGnt + k) % NR;
        if (!found && req[w]) begin
          found = 1; expGnt[w] = 1'b1; expWin = w;
          expAddr = {RN{ra[w*AW +: AW]}};
        end
      end
    end
    if (expFire) begin
      expAddr = {RN{la}};
      expDin = ld;
    end
    #1;
  endtask

  // Commit the cycle to the model and move to the next falling edge.
  task automatic advance();
    int nden;
    if (rst_n) begin
      if (expFire) begin
        mTable[ld_addr] = ld_data;
        mTblValid = ld_last;
      end
      expRdValid = expGnt;
      if (expGnt != '0) begin
        mLastGnt = expWin;
        expRdData = mTable[rd_addr[expWin*AW +: AW]];
      end
      nden = $countones(rd_req & ~expGnt);
`ifdef HUFF_SCHED_STALL_CNT_EN
      mStall = (mStall + nden > 65535) ? 65535 : mStall + nden;
`else
      nden = 0;
`endif
      mReady = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    mReady = 0; mTblValid = 0; mLastGnt = NR - 1; mStall = 0;
    expRdValid = '0; expRdData = '0; expGnt = '0; expFire = 0;
  endtask

  task automatic test_reset();
    ld_valid = 1'b1; ld_addr = 8'h11; ld_data = '1; ld_last = 1'b1;
    rd_req = '1; rd_addr = '0;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({ld_ready, tbl_valid, rd_gnt, rd_valid, rom_we} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0", {ld_ready, tbl_valid, rd_gnt, rd_valid, rom_we});
    end
    checks++;
    if (rd_data !== '0 || rom_addr !== '0 || rom_din !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data rd_data=%h rom_addr=%h rom_din=%h exp=0", rd_data, rom_addr, rom_din);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_stall got=%0d exp=0", stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    advance();
    checks++;
    if (ld_ready !== 1'b1 || tbl_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset ld_ready=%b tbl_valid=%b exp=1/0", ld_ready, tbl_valid);
    end
  endtask

  task automatic test_load_full();
    int weCnt;
    weCnt = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, AW'(i), beat(i), i == 255, NR'($urandom), (NR*AW)'($urandom));
      if (rom_we === 1'b1) weCnt++;
      checks++;
      if (rom_addr !== expAddr || rom_din !== expDin || rd_gnt !== '0 || ld_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL load_beat i=%0d addr=%h din=%h gnt=%b exp addr=%h din=%h gnt=0",
                 i, rom_addr, rom_din, rd_gnt, expAddr, expDin);
      end
      advance();
      checks++;
      if (tbl_valid !== (i == 255)) begin
        errors++;
        $display("[TB] FAIL load_tbl_valid i=%0d got=%b exp=%b", i, tbl_valid, i == 255);
      end
    end
    checks++;
    if (weCnt != 256) begin
      errors++;
      $display("[TB] FAIL load_we_cycles got=%0d exp=256", weCnt);
    end
  endtask

  task automatic test_single_read();
    drive(1'b0, '0, '0, 1'b0, 2'b01, {8'd0, 8'd7});
    checks++;
    if (rd_gnt !== 2'b01 || rom_addr !== {8'd7, 8'd7} || rom_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_gnt gnt=%b addr=%h we=%b exp 01/0707/0", rd_gnt, rom_addr, rom_we);
    end
    advance();
    checks++;
    if (rd_valid !== 2'b01 || rd_data !== {64'd263, 64'd7}) begin
      errors++;
      $display("[TB] FAIL single_resp valid=%b data=%h exp 01/{263,7}", rd_valid, rd_data);
    end
    drive(1'b0, '0, '0, 1'b0, 2'b00, '0);
    advance();
    checks++;
    if (rd_valid !== 2'b00 || rd_data !== {64'd263, 64'd7}) begin
      errors++;
      $display("[TB] FAIL single_hold valid=%b data=%h exp 00/{263,7}", rd_valid, rd_data);
    end
    // requester 1 alone, so the contention test starts from requester 0
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, '0, '0, 1'b0, 2'b10, {8'd9, 8'd0});
      checks++;
      if (rd_gnt !== 2'b10) begin
        errors++;
        $display("[TB] FAIL solo_gnt c=%0d got=%b exp=10", c, rd_gnt);
      end
      advance();
      checks++;
      if (rd_valid !== 2'b10 || rd_data !== {64'd265, 64'd9}) begin
        errors++;
        $display("[TB] FAIL solo_resp c=%0d valid=%b data=%h exp 10/{265,9}", c, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] want;
    logic [RW-1:0] wantData;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, '0, 1'b0, 2'b11, {8'd5, 8'd3});
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      wantData = (c % 2 == 0) ? {64'd259, 64'd3} : {64'd261, 64'd5};
      checks++;
      if (rd_gnt !== want || rd_gnt !== expGnt) begin
        errors++;
        $display("[TB] FAIL b2b_gnt c=%0d got=%b exp=%b", c, rd_gnt, want);
      end
      advance();
      checks++;
      if (rd_valid !== want || rd_data !== wantData) begin
        errors++;
        $display("[TB] FAIL b2b_resp c=%0d valid=%b data=%h exp %b/%h", c, rd_valid, rd_data, want, wantData);
      end
    end
  endtask

  task automatic test_stall();
    int s0;
    int want;
    s0 = int'(stall_cnt);
`ifdef HUFF_SCHED_STALL_CNT_EN
    want = 10;
`else
    want = 0;
`endif
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, '0, '0, 1'b0, 2'b11, NR*AW'($urandom));
      advance();
    end
    checks++;
    if (int'(stall_cnt) - s0 != want || int'(stall_cnt) != mStall) begin
      errors++;
      $display("[TB] FAIL stall_delta got=%0d exp=%0d (cnt=%0d model=%0d)", int'(stall_cnt) - s0, want, stall_cnt, mStall);
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 8'd3, beat(3), 1'b0, 2'b11, {8'd5, 8'd3});
    checks++;
    if (rd_gnt !== 2'b00 || ld_ready !== 1'b1 || rom_we !== 1'b1 || rom_addr !== {8'd3, 8'd3}) begin
      errors++;
      $display("[TB] FAIL prio_first gnt=%b ready=%b we=%b addr=%h exp 00/1/1/0303", rd_gnt, ld_ready, rom_we, rom_addr);
    end
    advance();
    checks++;
    if (tbl_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_tbl_drop got=%b exp=0", tbl_valid);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, '0, 1'b0, 2'b11, {8'd5, 8'd3});
      checks++;
      if (rd_gnt !== 2'b00) begin
        errors++;
        $display("[TB] FAIL prio_idle_gnt c=%0d got=%b exp=00", c, rd_gnt);
      end
      advance();
    end
    for (int i = 4; i <= 6; i++) begin
      drive(1'b1, AW'(i), beat(i), i == 6, 2'b11, {8'd5, 8'd3});
      checks++;
      if (rd_gnt !== 2'b00 || rom_we !== 1'b1) begin
        errors++;
        $display("[TB] FAIL prio_beat_gnt i=%0d gnt=%b we=%b exp 00/1", i, rd_gnt, rom_we);
      end
      advance();
    end
    checks++;
    if (tbl_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL prio_tbl_back got=%b exp=1", tbl_valid);
    end
    drive(1'b0, '0, '0, 1'b0, 2'b11, {8'd5, 8'd3});
    checks++;
    if (rd_gnt === 2'b00 || rd_gnt !== expGnt) begin
      errors++;
      $display("[TB] FAIL prio_resume got=%b exp=%b", rd_gnt, expGnt);
    end
    advance();
  endtask

  task automatic test_random();
    bit ldv;
    for (int c = 0; c < 300; c++) begin
      ldv = ($urandom_range(0, 15) == 0);
      drive(ldv, AW'($urandom), RW'({$urandom, $urandom, $urandom, $urandom}),
            ($urandom_range(0, 1) == 1), NR'($urandom), (NR*AW)'($urandom));
      checks++;
      if (rd_gnt !== expGnt) begin
        errors++;
        $display("[TB] FAIL rand_gnt c=%0d got=%b exp=%b", c, rd_gnt, expGnt);
      end
      checks++;
      if (rom_we !== expFire || rom_addr !== expAddr || rom_din !== expDin) begin
        errors++;
        $display("[TB] FAIL rand_rom c=%0d we=%b addr=%h din=%h exp %b/%h/%h", c, rom_we, rom_addr, rom_din, expFire, expAddr, expDin);
      end
      advance();
      checks++;
      if (rd_valid !== expRdValid || rd_data !== expRdData) begin
        errors++;
        $display("[TB] FAIL rand_resp c=%0d valid=%b data=%h exp %b/%h", c, rd_valid, rd_data, expRdValid, expRdData);
      end
      checks++;
      if (tbl_valid !== mTblValid) begin
        errors++;
        $display("[TB] FAIL rand_tbl c=%0d got=%b exp=%b", c, tbl_valid, mTblValid);
      end
    end
    checks++;
    if (int'(stall_cnt) != mStall) begin
      errors++;
      $display("[TB] FAIL rand_stall got=%0d exp=%0d", stall_cnt, mStall);
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, AW'(i), beat(i + 1000), 1'b0, 2'b11, {8'd5, 8'd3});
      advance();
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({ld_ready, tbl_valid, rd_gnt, rd_valid, rom_we} !== 7'b0 || rd_data !== '0 ||
        rom_addr !== '0 || rom_din !== '0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL midload_reset ctrl=%b data=%h addr=%h stall=%0d exp all 0",
               {ld_ready, tbl_valid, rd_gnt, rd_valid, rom_we}, rd_data, rom_addr, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, '0, '0, 1'b0, 2'b11, {8'd5, 8'd3});
      checks++;
      if (rd_gnt !== 2'b00) begin
        errors++;
        $display("[TB] FAIL midload_nogrant c=%0d got=%b exp=00", c, rd_gnt);
      end
      advance();
    end
    // 256 beats with no ld_last must keep the table invalid
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, AW'(i), beat(i), 1'b0, 2'b11, {8'd5, 8'd3});
      advance();
      checks++;
      if (tbl_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL nolast_tbl i=%0d got=%b exp=0", i, tbl_valid);
      end
    end
    drive(1'b0, '0, '0, 1'b0, 2'b11, {8'd5, 8'd3});
    checks++;
    if (rd_gnt !== 2'b00) begin
      errors++;
      $display("[TB] FAIL nolast_gnt got=%b exp=00", rd_gnt);
    end
    advance();
    drive(1'b1, 8'd255, beat(255), 1'b1, 2'b00, '0);
    advance();
    checks++;
    if (tbl_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_tbl got=%b exp=1", tbl_valid);
    end
    drive(1'b0, '0, '0, 1'b0, 2'b11, {8'd5, 8'd3});
    checks++;
    if (rd_gnt !== 2'b01) begin
      errors++;
      $display("[TB] FAIL reload_first_gnt got=%b exp=01", rd_gnt);
    end
    advance();
    checks++;
    if (rd_valid !== 2'b01 || rd_data !== {64'd259, 64'd3}) begin
      errors++;
      $display("[TB] FAIL reload_resp valid=%b data=%h exp 01/{259,3}", rd_valid, rd_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mTable[i] = '0;
    test_reset();
    test_load_full();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_load_priority();
    test_random();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
